// File: rtl/alu_exec_pkg.sv
// Shared constants and enumerations for the multi-cycle ALU execute stage.
// The encodings match the op/shift/state field values seen on the ports.
package alu_exec_pkg;

  localparam int DATA_W = 8;
  localparam int REG_AW = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_CMP = 2'b01,
    OP_AND = 2'b10,
    OP_MVN = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } state_e;

endpackage

// File: rtl/alu_shifter.sv
// Single-bit barrel stage applied to operand B ahead of the ALU.
// Purely combinational; the shift amount is always one position.
module alu_shifter
  import alu_exec_pkg::*;
(
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        shift,
  output logic [DATA_W-1:0] b_sh
);

  // Select the shifted form of B.
  always_comb begin
    b_sh = b;
    case (shift)
      SH_NONE: b_sh = b;
      SH_LSL:  b_sh = {b[DATA_W-2:0], 1'b0};
      SH_LSR:  b_sh = {1'b0, b[DATA_W-1:1]};
      SH_ASR:  b_sh = {b[DATA_W-1], b[DATA_W-1:1]};
      default: b_sh = b;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute stage: fetches A and B over one register-file read port,
// shifts B, runs ADD/CMP/AND/MVN, updates Z/N/V and writes the result back.
module alu_exec_unit
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [1:0]        shift,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  output logic [REG_AW-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic              w_en,
  output logic [REG_AW-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              busy,
  output logic              done,
  output logic              Z,
  output logic              N,
  output logic              V
);

  localparam int MSB = DATA_W - 1;

  state_e            state_r;
  state_e            next_state_s;
  op_e               op_r;
  logic [1:0]        shift_r;
  logic [REG_AW-1:0] rd_r;
  logic [REG_AW-1:0] rm_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] b_sh_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              v_s;

  alu_shifter u_shifter (
    .b     (b_r),
    .shift (shift_r),
    .b_sh  (b_sh_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state sequencing; every state past IDLE lasts one cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = S_LOAD_A;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_LOAD_A: next_state_s = S_LOAD_B;
      S_LOAD_B: next_state_s = S_EXEC;
      S_EXEC:   next_state_s = S_WB;
      S_WB:     next_state_s = S_IDLE;
      default:  next_state_s = S_IDLE;
    endcase
  end

  // ALU result and signed-overflow detection on A and shifted B.
  always_comb begin
    alu_res_s = '0;
    v_s       = 1'b0;
    case (op_r)
      OP_ADD: begin
        alu_res_s = a_r + b_sh_s;
        v_s       = (a_r[MSB] == b_sh_s[MSB]) && (alu_res_s[MSB] != a_r[MSB]);
      end
      OP_CMP: begin
        alu_res_s = a_r - b_sh_s;
        v_s       = (a_r[MSB] != b_sh_s[MSB]) && (alu_res_s[MSB] != a_r[MSB]);
      end
      OP_AND: begin
        alu_res_s = a_r & b_sh_s;
        v_s       = 1'b0;
      end
      OP_MVN: begin
        alu_res_s = ~b_sh_s;
        v_s       = 1'b0;
      end
      default: begin
        alu_res_s = '0;
        v_s       = 1'b0;
      end
    endcase
  end

  // Instruction latches, operand capture, flags and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r    <= OP_ADD;
      shift_r <= 2'b00;
      rd_r    <= '0;
      rm_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      r_addr  <= '0;
      w_en    <= 1'b0;
      w_addr  <= '0;
      w_data  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Z       <= 1'b0;
      N       <= 1'b0;
      V       <= 1'b0;
    end else begin
      busy <= (next_state_s != S_IDLE);
      done <= (state_r == S_EXEC);
      w_en <= (state_r == S_EXEC) && (op_r != OP_CMP);

      // Read address is set up one edge early so it is stable for the whole load cycle.
      case (next_state_s)
        S_LOAD_A: r_addr <= rn;
        S_LOAD_B: r_addr <= rm_r;
        default:  r_addr <= '0;
      endcase

      case (state_r)
        S_IDLE: begin
          if (start) begin
            op_r    <= op_e'(op);
            shift_r <= shift;
            rd_r    <= rd;
            rm_r    <= rm;
          end
        end
        S_LOAD_A: a_r <= r_data;
        S_LOAD_B: b_r <= r_data;
        S_EXEC: begin
          Z <= (alu_res_s == '0);
          N <= alu_res_s[MSB];
          V <= v_s;
          // CMP leaves the write port holding the last written address and data.
          if (op_r != OP_CMP) begin
            w_addr <= rd_r;
            w_data <= alu_res_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
